// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: shares one AXI master port among ICache/DCache refills and DCache writes.
// Define MEM_ARB_RR_EN for round-robin read arbitration; otherwise DCache reads always win.
module mem_req_arbiter #(
    parameter int ADDR_W = 32,
    parameter int BLK_W  = 256,
    parameter int OFS_W  = 5
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              ic_rreq,
    input  logic [ADDR_W-1:0] ic_raddr,
    output logic              ic_rgnt,
    output logic              ic_rvalid,
    output logic [BLK_W-1:0]  ic_rdata,
    input  logic              dc_rreq,
    input  logic [ADDR_W-1:0] dc_raddr,
    output logic              dc_rgnt,
    output logic              dc_rvalid,
    output logic [BLK_W-1:0]  dc_rdata,
    input  logic [3:0]        dc_wen,
    input  logic [ADDR_W-1:0] dc_waddr,
    input  logic [31:0]       dc_wdata,
    output logic              dc_wgnt,
    output logic              bus_ren,
    output logic [ADDR_W-1:0] bus_raddr,
    input  logic              bus_rrdy,
    input  logic              bus_rvalid,
    input  logic [BLK_W-1:0]  bus_rdata,
    output logic [3:0]        bus_wen,
    output logic [ADDR_W-1:0] bus_waddr,
    output logic [31:0]       bus_wdata,
    input  logic              bus_wrdy
);

    typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT} rstate_t;
    typedef enum logic [1:0] {W_EMPTY, W_FULL, W_SENT, W_DRAIN} wstate_t;

    rstate_t           r_rstate, w_rnext;
    wstate_t           r_wstate, w_wnext;
    logic [ADDR_W-1:0] r_raddr;
    logic              r_owner;
    logic              r_ren;
    logic              r_ic_rgnt, r_dc_rgnt;
    logic              r_ic_rvalid, r_dc_rvalid;
    logic [BLK_W-1:0]  r_ic_rdata, r_dc_rdata;
    logic [3:0]        r_wen_buf;
    logic [ADDR_W-1:0] r_waddr_buf;
    logic [31:0]       r_wdata_buf;
    logic              r_wgnt, r_bwen;

    logic w_buf_busy, w_hazard;
    logic w_ic_elig, w_dc_elig, w_pick_dc;
    logic w_grant, w_issue_done, w_deliver;
    logic w_wcap, w_wsend;

    // A read to the block held in (or entering) the write buffer must wait for the write
    assign w_buf_busy = (r_wstate != W_EMPTY);
    assign w_hazard   = w_buf_busy
        ? (dc_raddr[ADDR_W-1:OFS_W] == r_waddr_buf[ADDR_W-1:OFS_W])
        : ((dc_wen != 4'b0) && (dc_raddr[ADDR_W-1:OFS_W] == dc_waddr[ADDR_W-1:OFS_W]));
    assign w_ic_elig  = ic_rreq;
    assign w_dc_elig  = dc_rreq && !w_hazard;

`ifdef MEM_ARB_RR_EN
    logic r_ptr;

    assign w_pick_dc = w_dc_elig && (!w_ic_elig || r_ptr);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_ptr <= 1'b0;
        end else if (w_grant) begin
            r_ptr <= ~w_pick_dc;
        end
    end
`else
    assign w_pick_dc = w_dc_elig;
`endif

    always_comb begin
        w_rnext      = r_rstate;
        w_grant      = 1'b0;
        w_issue_done = 1'b0;
        w_deliver    = 1'b0;
        unique case (r_rstate)
            R_IDLE: begin
                if (bus_rrdy && (w_ic_elig || w_dc_elig)) begin
                    w_grant = 1'b1;
                    w_rnext = R_ISSUE;
                end
            end
            R_ISSUE: begin
                if (r_ren && !bus_rrdy) begin
                    w_issue_done = 1'b1;
                    w_rnext      = R_WAIT;
                end
            end
            R_WAIT: begin
                if (bus_rvalid && bus_rrdy) begin
                    w_deliver = 1'b1;
                    w_rnext   = R_IDLE;
                end
            end
            default: w_rnext = R_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_rstate    <= R_IDLE;
            r_raddr     <= '0;
            r_owner     <= 1'b0;
            r_ren       <= 1'b0;
            r_ic_rgnt   <= 1'b0;
            r_dc_rgnt   <= 1'b0;
            r_ic_rvalid <= 1'b0;
            r_dc_rvalid <= 1'b0;
            r_ic_rdata  <= '0;
            r_dc_rdata  <= '0;
        end else begin
            r_rstate    <= w_rnext;
            r_ic_rgnt   <= w_grant && !w_pick_dc;
            r_dc_rgnt   <= w_grant && w_pick_dc;
            r_ren       <= (r_rstate == R_ISSUE) && !w_issue_done;
            r_ic_rvalid <= w_deliver && !r_owner;
            r_dc_rvalid <= w_deliver && r_owner;
            if (w_grant) begin
                r_raddr <= w_pick_dc ? dc_raddr : ic_raddr;
                r_owner <= w_pick_dc;
            end
            if (w_deliver && !r_owner) begin
                r_ic_rdata <= bus_rdata;
            end
            if (w_deliver && r_owner) begin
                r_dc_rdata <= bus_rdata;
            end
        end
    end

    always_comb begin
        w_wnext = r_wstate;
        w_wcap  = 1'b0;
        w_wsend = 1'b0;
        unique case (r_wstate)
            W_EMPTY: begin
                if (dc_wen != 4'b0) begin
                    w_wcap  = 1'b1;
                    w_wnext = W_FULL;
                end
            end
            W_FULL: begin
                if (bus_wrdy) begin
                    w_wsend = 1'b1;
                    w_wnext = W_SENT;
                end
            end
            W_SENT: begin
                if (!bus_wrdy) begin
                    w_wnext = W_DRAIN;
                end
            end
            W_DRAIN: begin
                if (bus_wrdy) begin
                    w_wnext = W_EMPTY;
                end
            end
            default: w_wnext = W_EMPTY;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_wstate    <= W_EMPTY;
            r_wen_buf   <= 4'b0;
            r_waddr_buf <= '0;
            r_wdata_buf <= '0;
            r_wgnt      <= 1'b0;
            r_bwen      <= 1'b0;
        end else begin
            r_wstate <= w_wnext;
            r_wgnt   <= w_wcap;
            r_bwen   <= w_wsend;
            if (w_wcap) begin
                r_wen_buf   <= dc_wen;
                r_waddr_buf <= dc_waddr;
                r_wdata_buf <= dc_wdata;
            end
        end
    end

    assign ic_rgnt   = r_ic_rgnt;
    assign dc_rgnt   = r_dc_rgnt;
    assign ic_rvalid = r_ic_rvalid;
    assign dc_rvalid = r_dc_rvalid;
    assign ic_rdata  = r_ic_rdata;
    assign dc_rdata  = r_dc_rdata;
    assign bus_ren   = r_ren;
    assign bus_raddr = r_raddr;
    assign dc_wgnt   = r_wgnt;
    assign bus_wen   = r_bwen ? r_wen_buf : 4'b0;
    assign bus_waddr = r_waddr_buf;
    assign bus_wdata = r_wdata_buf;

endmodule
